id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that consumes the two 64-bit read ports of the 32x64 register file.
- Captures decoded control and operands and produces forwarded operands for the EX stage.
- Handles the three in-flight data hazards:
  - same-edge writeback bypass at capture;
  - EX/MEM and MEM/WB forwarding in EX;
  - one-cycle load-use bubble.
- X31 is the zero register throughout and is never forwarded.

Parameters:
- DW, 64, datapath width
- AW, 5, register address width
- ZR, 31, zero-register index (never written, never forwarded)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- valid_id  input  1  decode stage holds a valid instruction
- Rn_id  input  AW  first source register (drives regfile ReadRegister1)
- Rm_id  input  AW  second source register (drives regfile ReadRegister2)
- Rd_id  input  AW  destination register
- RegWrite_id  input  1  instruction writes Rd
- MemRead_id  input  1  instruction is a load
- ReadData1  input  DW  regfile port 1 data for Rn_id
- ReadData2  input  DW  regfile port 2 data for Rm_id
- exmem_RegWrite  input  1  EX/MEM instruction writes a register
- exmem_Rd  input  AW  EX/MEM destination
- exmem_data  input  DW  EX/MEM ALU result
- memwb_RegWrite  input  1  MEM/WB instruction writes a register (same signal as regfile RegWrite)
- memwb_Rd  input  AW  MEM/WB destination (same as regfile WriteRegister)
- memwb_data  input  DW  MEM/WB result (same as regfile WriteData)
- ex_hold  input  1  EX stage cannot advance
- flush  input  1  squash the instruction entering EX (branch taken)
- valid_ex  output  1  EX holds a valid instruction
- Rd_ex  output  AW  registered destination
- RegWrite_ex  output  1  registered, forced 0 when valid_ex=0
- MemRead_ex  output  1  registered, forced 0 when valid_ex=0
- OpA_ex  output  DW  forwarded operand A
- OpB_ex  output  DW  forwarded operand B
- fwdA_sel  output  2  0=captured, 1=EX/MEM, 2=MEM/WB
- fwdB_sel  output  2  same encoding for operand B
- stall_id  output  1  decode/fetch must hold this cycle

Behaviour:
- Reset (async, any cycle):
  - valid_ex, RegWrite_ex, MemRead_ex = 0.
  - Rd_ex = ZR.
  - Captured operands, Rn_ex and Rm_ex = 0.
  - stall_id = 0 while reset is high.
  - An instruction in flight at reset is discarded.
- Load-use hazard (combinational), all of the following true:
  - valid_ex & MemRead_ex & valid_id;
  - Rd_ex != ZR;
  - Rd_ex == Rn_id or Rd_ex == Rm_id.
- stall_id = load_use | ex_hold.
- Next-state priority at each rising edge:
  1. flush: valid_ex <= 0, other fields don't-care but RegWrite/MemRead outputs gated to 0. Flush overrides ex_hold and load_use.
  2. ex_hold: all registers hold.
  3. load_use: bubble, valid_ex <= 0; decode holds, so the same instruction is re-presented next cycle.
  4. Otherwise: capture valid_id, Rn/Rm/Rd, RegWrite, MemRead and operands A/B.
- Capture bypass (writeback collision):
  - If memwb_RegWrite & memwb_Rd != ZR & memwb_Rd == Rn_id, capture memwb_data as A; else capture ReadData1. Same rule for B with Rm_id/ReadData2.
  - If Rn_id == ZR, capture 0 regardless of ReadData1. Same for Rm_id.
- EX forwarding (combinational from registered Rn_ex/Rm_ex), for operand A:
  - If exmem_RegWrite & exmem_Rd != ZR & exmem_Rd == Rn_ex: OpA_ex = exmem_data, fwdA_sel = 1.
  - Else if memwb_RegWrite & memwb_Rd != ZR & memwb_Rd == Rn_ex: OpA_ex = memwb_data, fwdA_sel = 2.
  - Else: captured value, fwdA_sel = 0.
  - EX/MEM wins over MEM/WB when both match. Operand B identical.
- While valid_ex = 0, fwd selects still evaluate but outputs are don't-care; RegWrite_ex and MemRead_ex are 0.
- Latency: valid_id to valid_ex is 1 cycle with no hazard, 2 cycles with a load-use bubble.
- A load with Rd = ZR never stalls.
- Rn_id == Rm_id == load Rd produces one bubble, not two.

Test Plan:
- Reset mid-operation: valid_ex=1, assert reset between edges -> valid_ex, RegWrite_ex, MemRead_ex = 0 immediately, stall_id=0, Rd_ex=31.
- Back-to-back ALU dependency: ADD X1 then ADD X2,X1,X1 with exmem_Rd=1, exmem_data=0x55 -> OpA_ex = OpB_ex = 0x55, fwdA_sel = fwdB_sel = 1.
- Double match: exmem_Rd=3 data 0xAA and memwb_Rd=3 data 0xBB, Rn_ex=3 -> OpA_ex=0xAA, fwdA_sel=1.
- Writeback collision: memwb_Rd=7, memwb_data=0x1234, ReadData1=0 (stale), Rn_id=7 -> after edge OpA_ex=0x1234, fwdA_sel=0.
- Load-use: LDUR X4 in EX, next instruction uses X4 -> stall_id=1 for exactly 1 cycle, one valid_ex=0 bubble, then forward from MEM/WB gives fwdA_sel=2. Repeat with Rd=31 -> no stall, and Rn=31 -> OpA_ex=0.
- Flush with ex_hold and load_use all high -> valid_ex=0 next cycle, RegWrite_ex=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with writeback bypass, EX forwarding and load-use bubble
module id_ex_operand_stage #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int ZR = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_id,
  input  logic [AW-1:0] Rn_id,
  input  logic [AW-1:0] Rm_id,
  input  logic [AW-1:0] Rd_id,
  input  logic          RegWrite_id,
  input  logic          MemRead_id,
  input  logic [DW-1:0] ReadData1,
  input  logic [DW-1:0] ReadData2,
  input  logic          exmem_RegWrite,
  input  logic [AW-1:0] exmem_Rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_RegWrite,
  input  logic [AW-1:0] memwb_Rd,
  input  logic [DW-1:0] memwb_data,
  input  logic          ex_hold,
  input  logic          flush,
  output logic          valid_ex,
  output logic [AW-1:0] Rd_ex,
  output logic          RegWrite_ex,
  output logic          MemRead_ex,
  output logic [DW-1:0] OpA_ex,
  output logic [DW-1:0] OpB_ex,
  output logic [1:0]    fwdA_sel,
  output logic [1:0]    fwdB_sel,
  output logic          stall_id
);

  localparam logic [AW-1:0] ZR_A = AW'(ZR);

  logic          valid_q, valid_d;
  logic [AW-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic          regwrite_q, regwrite_d, memread_q, memread_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;

  logic          load_use;
  logic [DW-1:0] cap_a, cap_b;
  logic          exmem_ok, memwb_ok;

  assign exmem_ok = exmem_RegWrite && (exmem_Rd != ZR_A);
  assign memwb_ok = memwb_RegWrite && (memwb_Rd != ZR_A);

  assign load_use = valid_q && memread_q && valid_id && (rd_q != ZR_A) &&
                    ((rd_q == Rn_id) || (rd_q == Rm_id));

  assign stall_id = !reset && (load_use || ex_hold);

  // Regfile write and read land on the same edge, so the read port is stale on a collision.
  always_comb begin
    cap_a = ReadData1;
    cap_b = ReadData2;
    if (memwb_ok && (memwb_Rd == Rn_id)) cap_a = memwb_data;
    if (memwb_ok && (memwb_Rd == Rm_id)) cap_b = memwb_data;
    if (Rn_id == ZR_A) cap_a = '0;
    if (Rm_id == ZR_A) cap_b = '0;
  end

  always_comb begin
    valid_d    = valid_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ex_hold) begin
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d = 1'b0;
    end else begin
      valid_d    = valid_id;
      rn_d       = Rn_id;
      rm_d       = Rm_id;
      rd_d       = Rd_id;
      regwrite_d = RegWrite_id;
      memread_d  = MemRead_id;
      opa_d      = cap_a;
      opb_d      = cap_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rn_q       <= '0;
      rm_q       <= '0;
      rd_q       <= ZR_A;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
    end
  end

  // EX/MEM is the younger result, so it takes priority over MEM/WB.
  always_comb begin
    OpA_ex   = opa_q;
    fwdA_sel = 2'd0;
    if (exmem_ok && (exmem_Rd == rn_q)) begin
      OpA_ex   = exmem_data;
      fwdA_sel = 2'd1;
    end else if (memwb_ok && (memwb_Rd == rn_q)) begin
      OpA_ex   = memwb_data;
      fwdA_sel = 2'd2;
    end
  end

  always_comb begin
    OpB_ex   = opb_q;
    fwdB_sel = 2'd0;
    if (exmem_ok && (exmem_Rd == rm_q)) begin
      OpB_ex   = exmem_data;
      fwdB_sel = 2'd1;
    end else if (memwb_ok && (memwb_Rd == rm_q)) begin
      OpB_ex   = memwb_data;
      fwdB_sel = 2'd2;
    end
  end

  assign valid_ex    = valid_q;
  assign Rd_ex       = rd_q;
  assign RegWrite_ex = valid_q && regwrite_q;
  assign MemRead_ex  = valid_q && memread_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  localparam int K_VALID = 0, K_RD = 1, K_RW = 2, K_MR = 3, K_OPA = 4,
                 K_OPB = 5, K_FA = 6, K_FB = 7, K_STALL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_id;
  logic [4:0]  Rn_id, Rm_id, Rd_id;
  logic        RegWrite_id, MemRead_id;
  logic [63:0] ReadData1, ReadData2;
  logic        exmem_RegWrite;
  logic [4:0]  exmem_Rd;
  logic [63:0] exmem_data;
  logic        memwb_RegWrite;
  logic [4:0]  memwb_Rd;
  logic [63:0] memwb_data;
  logic        ex_hold, flush;
  logic        valid_ex;
  logic [4:0]  Rd_ex;
  logic        RegWrite_ex, MemRead_ex;
  logic [63:0] OpA_ex, OpB_ex;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic        stall_id;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .valid_id(valid_id),
    .Rn_id(Rn_id), .Rm_id(Rm_id), .Rd_id(Rd_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .exmem_RegWrite(exmem_RegWrite), .exmem_Rd(exmem_Rd), .exmem_data(exmem_data),
    .memwb_RegWrite(memwb_RegWrite), .memwb_Rd(memwb_Rd), .memwb_data(memwb_data),
    .ex_hold(ex_hold), .flush(flush),
    .valid_ex(valid_ex), .Rd_ex(Rd_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .OpA_ex(OpA_ex), .OpB_ex(OpB_ex), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
    .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] observe(int k);
    case (k)
      K_VALID: return {63'd0, valid_ex};
      K_RD:    return {59'd0, Rd_ex};
      K_RW:    return {63'd0, RegWrite_ex};
      K_MR:    return {63'd0, MemRead_ex};
      K_OPA:   return OpA_ex;
      K_OPB:   return OpB_ex;
      K_FA:    return {62'd0, fwdA_sel};
      K_FB:    return {62'd0, fwdB_sel};
      default: return {63'd0, stall_id};
    endcase
  endfunction

  task automatic expect_v(string tag, int k, logic [63:0] e);
    sb.push_back('{tag, k, e});
  endtask

  task automatic drain();
    exp_t x;
    logic [63:0] o;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.kind);
      total++;
      assert (o === x.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(logic v, logic [4:0] rn, logic [4:0] rm, logic [4:0] rd,
                          logic rw, logic mr, logic [63:0] d1, logic [63:0] d2);
    valid_id = v; Rn_id = rn; Rm_id = rm; Rd_id = rd;
    RegWrite_id = rw; MemRead_id = mr; ReadData1 = d1; ReadData2 = d2;
  endtask

  task automatic set_exmem(logic rw, logic [4:0] rd, logic [63:0] d);
    exmem_RegWrite = rw; exmem_Rd = rd; exmem_data = d;
  endtask

  task automatic set_memwb(logic rw, logic [4:0] rd, logic [63:0] d);
    memwb_RegWrite = rw; memwb_Rd = rd; memwb_data = d;
  endtask

  initial begin
    reset = 1'b1; ex_hold = 1'b1; flush = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_exmem(1'b0, 5'd0, 64'd0);
    set_memwb(1'b0, 5'd0, 64'd0);
    #12;
    expect_v("rst_valid", K_VALID, 64'd0);
    expect_v("rst_rd", K_RD, 64'd31);
    expect_v("rst_stall", K_STALL, 64'd0);
    drain();
    @(negedge clk);
    reset = 1'b0; ex_hold = 1'b0;

    // load in flight, then reset between edges
    drive_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 64'h11, 64'h22);
    tick();
    expect_v("cap_valid", K_VALID, 64'd1);
    expect_v("cap_mr", K_MR, 64'd1);
    expect_v("cap_rd", K_RD, 64'd5);
    drain();
    ex_hold = 1'b1;
    #2 reset = 1'b1;
    expect_v("midrst_valid", K_VALID, 64'd0);
    expect_v("midrst_rw", K_RW, 64'd0);
    expect_v("midrst_mr", K_MR, 64'd0);
    expect_v("midrst_stall", K_STALL, 64'd0);
    expect_v("midrst_rd", K_RD, 64'd31);
    drain();
    @(negedge clk);
    reset = 1'b0; ex_hold = 1'b0;

    // back-to-back ALU dependency through EX/MEM
    drive_id(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 64'h2, 64'h3);
    tick();
    drive_id(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 64'h0, 64'h0);
    expect_v("b2b_nostall", K_STALL, 64'd0);
    drain();
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_exmem(1'b1, 5'd1, 64'h55);
    expect_v("b2b_opa", K_OPA, 64'h55);
    expect_v("b2b_opb", K_OPB, 64'h55);
    expect_v("b2b_fa", K_FA, 64'd1);
    expect_v("b2b_fb", K_FB, 64'd1);
    expect_v("b2b_rw", K_RW, 64'd1);
    drain();
    set_exmem(1'b0, 5'd0, 64'd0);

    // double match, EX/MEM wins; then MEM/WB alone; zero-register never forwarded
    drive_id(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 64'h11, 64'h99);
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_exmem(1'b1, 5'd3, 64'hAA);
    set_memwb(1'b1, 5'd3, 64'hBB);
    expect_v("dbl_opa", K_OPA, 64'hAA);
    expect_v("dbl_fa", K_FA, 64'd1);
    expect_v("dbl_opb", K_OPB, 64'h99);
    expect_v("dbl_fb", K_FB, 64'd0);
    drain();
    exmem_RegWrite = 1'b0;
    expect_v("mw_opa", K_OPA, 64'hBB);
    expect_v("mw_fa", K_FA, 64'd2);
    drain();
    set_memwb(1'b1, 5'd9, 64'hCC);
    set_exmem(1'b0, 5'd9, 64'hDD);
    expect_v("mw_opb", K_OPB, 64'hCC);
    expect_v("mw_fb", K_FB, 64'd2);
    drain();
    set_memwb(1'b0, 5'd0, 64'd0);
    set_exmem(1'b0, 5'd0, 64'd0);

    // writeback collision bypass at capture, Rm=ZR captures zero
    drive_id(1'b1, 5'd7, 5'd31, 5'd12, 1'b1, 1'b0, 64'h0, 64'hDEAD);
    set_memwb(1'b1, 5'd7, 64'h1234);
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_memwb(1'b0, 5'd0, 64'd0);
    expect_v("wbc_opa", K_OPA, 64'h1234);
    expect_v("wbc_fa", K_FA, 64'd0);
    expect_v("wbc_opb_zr", K_OPB, 64'd0);
    drain();

    // load-use: one bubble then MEM/WB forward
    drive_id(1'b1, 5'd2, 5'd31, 5'd4, 1'b1, 1'b1, 64'h20, 64'h0);
    tick();
    drive_id(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 64'h0, 64'h50);
    expect_v("lu_stall", K_STALL, 64'd1);
    expect_v("lu_mr", K_MR, 64'd1);
    drain();
    tick();
    expect_v("lu_bubble", K_VALID, 64'd0);
    expect_v("lu_bub_mr", K_MR, 64'd0);
    expect_v("lu_bub_rw", K_RW, 64'd0);
    expect_v("lu_stall_once", K_STALL, 64'd0);
    drain();
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_memwb(1'b1, 5'd4, 64'hCAFE);
    expect_v("lu_valid", K_VALID, 64'd1);
    expect_v("lu_opa", K_OPA, 64'hCAFE);
    expect_v("lu_fa", K_FA, 64'd2);
    expect_v("lu_opb", K_OPB, 64'h50);
    drain();
    set_memwb(1'b0, 5'd0, 64'd0);

    // load to X31 never stalls; X31 source reads zero
    drive_id(1'b1, 5'd2, 5'd3, 5'd31, 1'b1, 1'b1, 64'h1, 64'h2);
    tick();
    drive_id(1'b1, 5'd31, 5'd31, 5'd6, 1'b1, 1'b0, 64'hFFFF, 64'hEEEE);
    expect_v("zr_nostall", K_STALL, 64'd0);
    drain();
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    expect_v("zr_valid", K_VALID, 64'd1);
    expect_v("zr_opa", K_OPA, 64'd0);
    expect_v("zr_fa", K_FA, 64'd0);
    drain();

    // both sources equal the load Rd: exactly one bubble
    drive_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 64'h1, 64'h2);
    tick();
    drive_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 64'h0, 64'h0);
    expect_v("two_stall", K_STALL, 64'd1);
    drain();
    tick();
    expect_v("two_bubble", K_VALID, 64'd0);
    expect_v("two_stall2", K_STALL, 64'd0);
    drain();
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    expect_v("two_valid", K_VALID, 64'd1);
    expect_v("two_rd", K_RD, 64'd9);
    drain();

    // ex_hold keeps EX contents
    drive_id(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 64'h1, 64'h2);
    tick();
    drive_id(1'b1, 5'd3, 5'd4, 5'd14, 1'b0, 1'b0, 64'h3, 64'h4);
    ex_hold = 1'b1;
    expect_v("hold_stall", K_STALL, 64'd1);
    drain();
    tick();
    ex_hold = 1'b0;
    expect_v("hold_rd", K_RD, 64'd13);
    expect_v("hold_valid", K_VALID, 64'd1);
    expect_v("hold_opa", K_OPA, 64'h1);
    drain();

    // flush beats ex_hold and load_use
    drive_id(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 64'h1, 64'h2);
    tick();
    drive_id(1'b1, 5'd4, 5'd6, 5'd7, 1'b1, 1'b0, 64'h0, 64'h0);
    ex_hold = 1'b1; flush = 1'b1;
    expect_v("fl_stall", K_STALL, 64'd1);
    drain();
    tick();
    ex_hold = 1'b0; flush = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    expect_v("fl_valid", K_VALID, 64'd0);
    expect_v("fl_rw", K_RW, 64'd0);
    expect_v("fl_mr", K_MR, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
